// File: rtl/mult_by_2_n_iter.sv
// mult_by_2_n_iter: iterative two's complement multiply by 2^n, one left shift per clock,
// saturating with early exit on overflow; valid/ready on both sides, one op in flight.
module mult_by_2_n_iter #(
    parameter int W     = 21,
    parameter int LOG2N = 6
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LOG2N-1:0] n,
    input  logic [W-1:0]     in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out,
    output logic             ovf
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             accept;
    logic             safe;

    assign accept = in_valid & in_ready;
    // a left shift keeps the value only while the two top bits agree
    assign safe   = acc_q[W-1] == acc_q[W-2];

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? ((n == '0) ? DONE : SHIFT) : IDLE;
            SHIFT:   state_d = (!safe || cnt_q == LOG2N'(1)) ? DONE : SHIFT;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (accept) begin
            acc_d = in;
            cnt_d = n;
            ovf_d = 1'b0;
        end else if (state_q == SHIFT) begin
            if (safe) begin
                acc_d = {acc_q[W-2:0], 1'b0};
                cnt_d = cnt_q - LOG2N'(1);
            end else begin
                acc_d = acc_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE) & ~srst;
        out_valid = state_q == DONE;
        out       = acc_q;
        ovf       = ovf_q;
    end
endmodule
